// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_rx
// Purpose  : PS/2 device-to-host byte receiver with odd-parity/stop/timeout
//            checking. Optional clock glitch filter: PS2_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_scancode_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic [7:0] scancode,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int c_TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   if (TIMEOUT_CYCLES < 2 || FILTER_LEN < 1) begin : g_param_check
      $error("ps2_scancode_rx: TIMEOUT_CYCLES must be >= 2 and FILTER_LEN >= 1");
   end

   state_t          r_state, w_next;
   logic            r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
   logic            r_clk_prev;
   logic            w_clk_src, w_fall;
   logic [7:0]      r_shift;
   logic [2:0]      r_bitcnt;
   logic            r_par;
   logic [c_TW-1:0] r_tcnt;
   logic [7:0]      r_scancode;
   logic            r_valid, r_frame_err;
   logic            w_start, w_shift, w_par_latch, w_load, w_err, w_timeout;

   // Clock flops idle high so that reset release never looks like a fall.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_dat_meta <= 1'b0;
         r_dat_sync <= 1'b0;
      end else begin
         r_clk_meta <= ps2_clock;
         r_clk_sync <= r_clk_meta;
         r_dat_meta <= ps2_data;
         r_dat_sync <= r_dat_meta;
      end
   end

`ifdef PS2_GLITCH_FILTER_EN
   localparam int c_FW = $clog2(FILTER_LEN + 1);
   localparam logic [c_FW-1:0] c_FMAX = c_FW'(FILTER_LEN - 1);

   logic            r_filt;
   logic [c_FW-1:0] r_fcnt;

   // Output follows the input only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_filt <= 1'b1;
         r_fcnt <= '0;
      end else if (r_clk_sync == r_filt) begin
         r_fcnt <= '0;
      end else if (r_fcnt == c_FMAX) begin
         r_filt <= r_clk_sync;
         r_fcnt <= '0;
      end else begin
         r_fcnt <= r_fcnt + c_FW'(1);
      end
   end

   assign w_clk_src = r_filt;
`else
   assign w_clk_src = r_clk_sync;
`endif

   always_ff @(posedge clock) begin
      if (reset) r_clk_prev <= 1'b1;
      else       r_clk_prev <= w_clk_src;
   end

   assign w_fall = r_clk_prev & ~w_clk_src;

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_par_latch = 1'b0;
      w_load      = 1'b0;
      w_err       = 1'b0;
      // A fall in the same cycle as expiry counts as a live line.
      w_timeout   = (r_state != S_IDLE) && (r_tcnt == c_TMAX) && !w_fall;
      case (r_state)
         S_IDLE: begin
            if (w_fall && !r_dat_sync) begin
               w_start = 1'b1;
               w_next  = S_DATA;
            end
         end
         S_DATA: begin
            if (w_fall) begin
               w_shift = 1'b1;
               if (r_bitcnt == 3'd7) w_next = S_PARITY;
            end
         end
         S_PARITY: begin
            if (w_fall) begin
               w_par_latch = 1'b1;
               w_next      = S_STOP;
            end
         end
         S_STOP: begin
            if (w_fall) begin
               if (r_dat_sync && (^{r_shift, r_par})) w_load = 1'b1;
               else                                   w_err  = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (w_timeout) begin
         w_err  = 1'b1;
         w_next = S_IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_par       <= 1'b0;
         r_tcnt      <= '0;
         r_scancode  <= 8'h00;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_valid     <= w_load;
         r_frame_err <= w_err;
         if (w_start) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
         end
         if (w_shift) begin
            r_shift  <= {r_dat_sync, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         if (w_par_latch) r_par <= r_dat_sync;
         if (w_load)      r_scancode <= r_shift;
         // Saturating so a stalled frame can never wrap back below expiry.
         if (w_fall || r_state == S_IDLE) r_tcnt <= '0;
         else if (r_tcnt != c_TMAX)       r_tcnt <= r_tcnt + c_TW'(1);
      end
   end

   assign scancode  = r_scancode;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
